// File: rtl/dac_spi_writer.sv
// dac_spi_writer: SPI master that shifts one {ctrl,data} frame MSB first to a 3-wire DAC per request.
// Optional LDAC_n strobe after each frame is built in when DAC_LDAC_EN is defined.
module dac_spi_writer #(
  parameter int CTRL_BITS = 8,
  parameter int DATA_BITS = 16,
  parameter int CLKDIV    = 2,
  parameter int CS_SETUP  = 2,
  parameter int CS_HOLD   = 2,
  parameter int CS_IDLE   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [CTRL_BITS-1:0] in_ctrl,
  input  logic [DATA_BITS-1:0] in_data,
  output logic                 in_ready,
  output logic                 done,
  output logic                 CS,
  output logic                 SCLK,
  output logic                 Din
`ifdef DAC_LDAC_EN
  ,
  output logic                 LDAC_n
`endif
);

  localparam int FRAME = CTRL_BITS + DATA_BITS;
`ifdef DAC_LDAC_EN
  localparam int GAP_LEN = (CS_IDLE > 4) ? CS_IDLE : 4;
`else
  localparam int GAP_LEN = CS_IDLE;
`endif
  localparam int CW = 16;
  localparam int BW = (FRAME > 1) ? $clog2(FRAME) : 1;

  localparam logic [CW-1:0] SETUP_LAST  = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] HALF_LAST   = CW'(CLKDIV - 1);
  localparam logic [CW-1:0] PERIOD_LAST = CW'(2 * CLKDIV - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(CS_HOLD - 1);
  localparam logic [CW-1:0] GAP_LAST    = CW'(GAP_LEN - 1);
  localparam logic [BW-1:0] BIT_FIRST   = BW'(FRAME - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  logic [2:0]       state;
  logic [CW-1:0]    cnt;
  logic [BW-1:0]    bit_cnt;
  logic [FRAME-2:0] shreg;
  logic [FRAME-1:0] frame_word;
  logic             hs;

  assign frame_word = {in_ctrl, in_data};
  assign hs         = in_valid & in_ready;

  // The frame MSB goes out on Din at the handshake edge; shreg keeps the remaining bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      in_ready <= 1'b0;
      done     <= 1'b0;
      CS       <= 1'b1;
      SCLK     <= 1'b0;
      Din      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          CS   <= 1'b1;
          SCLK <= 1'b0;
          done <= 1'b0;
          if (hs) begin
            state    <= S_SETUP;
            in_ready <= 1'b0;
            CS       <= 1'b0;
            Din      <= frame_word[FRAME-1];
            shreg    <= frame_word[FRAME-2:0];
            cnt      <= '0;
          end else begin
            in_ready <= 1'b1;
            Din      <= 1'b0;
          end
        end
        S_SETUP: begin
          if (cnt == SETUP_LAST) begin
            state   <= S_SHIFT;
            cnt     <= '0;
            bit_cnt <= BIT_FIRST;
            SCLK    <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        // Each bit period opens with the SCLK rise (and the Din update) and closes after the low half.
        S_SHIFT: begin
          if (cnt == PERIOD_LAST) begin
            cnt <= '0;
            if (bit_cnt == '0) begin
              state <= S_HOLD;
            end else begin
              bit_cnt <= bit_cnt - BW'(1);
              Din     <= shreg[FRAME-2];
              shreg   <= shreg << 1;
              SCLK    <= 1'b1;
            end
          end else begin
            cnt <= cnt + CW'(1);
            if (cnt == HALF_LAST) SCLK <= 1'b0;
          end
        end
        S_HOLD: begin
          if (cnt == HOLD_LAST) begin
            state <= S_GAP;
            cnt   <= '0;
            CS    <= 1'b1;
            done  <= 1'b1;
            Din   <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_GAP: begin
          done <= 1'b0;
          if (cnt == GAP_LAST) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state    <= S_IDLE;
          cnt      <= '0;
          in_ready <= 1'b0;
          done     <= 1'b0;
          CS       <= 1'b1;
          SCLK     <= 1'b0;
          Din      <= 1'b0;
        end
      endcase
    end
  end

`ifdef DAC_LDAC_EN
  // Registered one cycle ahead so LDAC_n is low on the third and fourth GAP cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      LDAC_n <= 1'b1;
    end else begin
      LDAC_n <= !((state == S_GAP) && ((cnt == CW'(1)) || (cnt == CW'(2))));
    end
  end
`endif

endmodule

// File: tb/tb_dac_spi_writer.sv
// tb_dac_spi_writer: random frames scored against a frame-level DAC model; a monitor pops the
// expected frame on every done pulse and checks data, edge counts and timing.
module tb_dac_spi_writer;

  localparam int CTRL_BITS = 8;
  localparam int DATA_BITS = 16;
  localparam int CLKDIV    = 2;
  localparam int CS_SETUP  = 2;
  localparam int CS_HOLD   = 2;
  localparam int CS_IDLE   = 4;
  localparam int FRAME     = CTRL_BITS + DATA_BITS;
`ifdef DAC_LDAC_EN
  localparam int GAP_LEN = (CS_IDLE > 4) ? CS_IDLE : 4;
`else
  localparam int GAP_LEN = CS_IDLE;
`endif
  localparam int CS_LOW_LEN = CS_SETUP + FRAME * 2 * CLKDIV + CS_HOLD;
  localparam int DONE_LAT   = 1 + CS_LOW_LEN;
  localparam int READY_LAT  = DONE_LAT + GAP_LEN + 1;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic [CTRL_BITS-1:0] in_ctrl = '0;
  logic [DATA_BITS-1:0] in_data = '0;
  logic                 in_ready;
  logic                 done;
  logic                 CS;
  logic                 SCLK;
  logic                 Din;
`ifdef DAC_LDAC_EN
  logic                 LDAC_n;
`endif

  dac_spi_writer #(
    .CTRL_BITS(CTRL_BITS), .DATA_BITS(DATA_BITS), .CLKDIV(CLKDIV),
    .CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_IDLE(CS_IDLE)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ctrl(in_ctrl), .in_data(in_data),
    .in_ready(in_ready), .done(done), .CS(CS), .SCLK(SCLK), .Din(Din)
`ifdef DAC_LDAC_EN
    , .LDAC_n(LDAC_n)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [FRAME-1:0] word;
    int               hs;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0;
  int n_fail = 0;

  int cyc = 0;
  int rises = 0;
  int falls = 0;
  int nbits = 0;
  int idle_edges = 0;
  int cs_low = 0;
  int cs_high = 0;
  int last_hs = 0;
  int ldac_low = 0;
  bit cs_high_valid = 1'b0;
  bit ready_pending = 1'b0;
  logic [FRAME-1:0] rx = '0;
  logic prev_sclk = 1'b0;
  logic prev_cs = 1'b1;
  logic prev_ready = 1'b0;
  logic prev_done = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Stimulus moves 2 time units after each rising edge, so the monitor at the falling edge sees settled values.
  task automatic stepCycle();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic [CTRL_BITS-1:0] c, input logic [DATA_BITS-1:0] d, input bit hold);
    bit got = 1'b0;
    in_ctrl  = c;
    in_data  = d;
    in_valid = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (in_ready) begin
        got = 1'b1;
        stepCycle();
        break;
      end
      stepCycle();
    end
    if (!hold) in_valid = 1'b0;
    checkOutput("handshake_taken", got, 1);
  endtask

  task automatic busyNoise(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = in_ready ? 1'b0 : 1'($urandom_range(0, 1));
      in_ctrl  = CTRL_BITS'($urandom);
      in_data  = DATA_BITS'($urandom);
      stepCycle();
    end
    in_valid = 1'b0;
  endtask

  task automatic waitIdle();
    bit ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (exp_q.size() == 0 && in_ready) begin
        ok = 1'b1;
        break;
      end
      stepCycle();
    end
    checkOutput("idle_reached", ok, 1);
  endtask

  task automatic monitorStep();
    exp_t e;
    bit cs_rise;
    bit cs_fall;
    cyc++;
    if (rst) begin
      exp_q.delete();
      rises = 0; falls = 0; nbits = 0; rx = '0; idle_edges = 0;
      cs_low = 0; cs_high = 0; cs_high_valid = 1'b0; ready_pending = 1'b0; ldac_low = 0;
      prev_sclk = SCLK; prev_cs = CS; prev_ready = in_ready; prev_done = done;
      return;
    end
    if (in_valid && in_ready) begin
      e.word = {in_ctrl, in_data};
      e.hs   = cyc;
      exp_q.push_back(e);
      rises = 0; falls = 0; nbits = 0; rx = '0;
    end
    if (SCLK != prev_sclk) begin
      if (CS) idle_edges++;
      if (SCLK) rises++;
      else begin
        falls++;
        if (!CS) begin
          rx = {rx[FRAME-2:0], Din};
          nbits++;
        end
      end
    end
    cs_rise = CS && !prev_cs;
    cs_fall = !CS && prev_cs;
    if (cs_rise) begin
      checkOutput("cs_low_len", 64'(cs_low), 64'(CS_LOW_LEN));
      cs_low = 0;
      cs_high = 0;
    end
    if (cs_fall) begin
      if (cs_high_valid) checkOutput("cs_high_min", (cs_high >= CS_IDLE), 1);
      cs_high_valid = 1'b0;
    end
    if (!CS) cs_low++;
    else cs_high++;
    if (done) begin
      checkOutput("done_expected", (exp_q.size() != 0), 1);
      checkOutput("done_width", prev_done, 0);
      checkOutput("din_in_gap", Din, 0);
      checkOutput("idle_sclk_edges", 64'(idle_edges), 0);
      idle_edges = 0;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checkOutput("frame_data", 64'(rx), 64'(e.word));
        checkOutput("frame_bits", 64'(nbits), 64'(FRAME));
        checkOutput("done_latency", 64'(cyc - e.hs), 64'(DONE_LAT));
        checkOutput("sclk_rises", 64'(rises), 64'(FRAME));
        checkOutput("sclk_falls", 64'(falls), 64'(FRAME));
        last_hs = e.hs;
        ready_pending = 1'b1;
        cs_high_valid = 1'b1;
      end
    end
`ifdef DAC_LDAC_EN
    if (!LDAC_n) begin
      ldac_low++;
      checkOutput("ldac_window",
                  ((cyc - last_hs) == DONE_LAT + 2) || ((cyc - last_hs) == DONE_LAT + 3), 1);
    end
`endif
    if (in_ready && !prev_ready && ready_pending) begin
      checkOutput("ready_latency", 64'(cyc - last_hs), 64'(READY_LAT));
`ifdef DAC_LDAC_EN
      checkOutput("ldac_low_cycles", 64'(ldac_low), 2);
      ldac_low = 0;
`endif
      ready_pending = 1'b0;
    end
    prev_sclk = SCLK; prev_cs = CS; prev_ready = in_ready; prev_done = done;
  endtask

  initial begin
    fork
      begin : monitor
        forever begin
          @(negedge clk);
          monitorStep();
        end
      end
      begin : stimulus
        repeat (3) stepCycle();
        checkOutput("reset_cs", CS, 1);
        checkOutput("reset_sclk", SCLK, 0);
        checkOutput("reset_din", Din, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_ready", in_ready, 0);
        rst = 1'b0;
        stepCycle();
        checkOutput("ready_after_reset", in_ready, 1);

        $display("[TB] single frame 0x00A5C3");
        applyStimulus(8'h00, 16'hA5C3, 1'b0);
        waitIdle();

        $display("[TB] back-to-back 0x0001 then 0xFFFF");
        applyStimulus(8'h00, 16'h0001, 1'b1);
        applyStimulus(8'h00, 16'hFFFF, 1'b0);
        waitIdle();

        $display("[TB] requests during a busy frame are ignored");
        applyStimulus(8'h3C, 16'h1234, 1'b0);
        repeat (8) stepCycle();
        in_valid = 1'b1; in_data = 16'hDEAD;
        stepCycle();
        in_valid = 1'b0;
        repeat (39) stepCycle();
        in_valid = 1'b1; in_data = 16'hBEEF;
        stepCycle();
        in_valid = 1'b0;
        waitIdle();

        $display("[TB] reset in the middle of a frame");
        applyStimulus(8'h81, 16'h5A5A, 1'b0);
        repeat (39) stepCycle();
        rst = 1'b1;
        #1;
        checkOutput("abort_cs", CS, 1);
        checkOutput("abort_sclk", SCLK, 0);
        checkOutput("abort_din", Din, 0);
        checkOutput("abort_done", done, 0);
        repeat (3) stepCycle();
        rst = 1'b0;
        stepCycle();
        checkOutput("ready_after_abort", in_ready, 1);
        applyStimulus(8'hC7, 16'h0F0F, 1'b0);
        waitIdle();

        $display("[TB] randomized frames");
        for (int k = 0; k < 10; k++) begin
          bit hold;
          hold = 1'($urandom_range(0, 1));
          repeat ($urandom_range(0, 6)) stepCycle();
          applyStimulus(CTRL_BITS'($urandom), DATA_BITS'($urandom), hold);
          if (!hold) busyNoise($urandom_range(5, 60));
        end
        in_valid = 1'b0;
        waitIdle();
        repeat (10) stepCycle();
        checkOutput("queue_drained", 64'(exp_q.size()), 0);
      end
    join_any
    disable fork;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
